draw_sprite: RTL and testbench
==============================

# draw_sprite

Pipelined sprite overlay stage that sits directly downstream of `vga_timing`, or of any earlier draw stage, on the `vga_if` chain. It overlays one SPRITE_W×SPRITE_H sprite, fetched from an external synchronous ROM, onto the incoming pixel stream. It forwards all timing signals delayed to match its own latency. Sprite position arrives through a valid/ready handshake and takes effect only at the start of vertical blanking, so the sprite never tears mid-frame.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels
- TRANSPARENT, 12'h000, ROM colour treated as see-through

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  reset; asynchronous, active-high
- in  vga_if.in  —  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb from the previous stage
- out  vga_if.out  —  same bundle, delayed 2 cycles, rgb possibly replaced
- xpos  in  11  requested sprite left edge
- ypos  in  11  requested sprite top edge
- pos_valid  in  1  xpos/ypos valid
- pos_ready  out  1  position buffer can accept
- rom_addr  out  $clog2(SPRITE_W*SPRITE_H)  sprite ROM address
- rom_data  in  12  ROM pixel, valid 1 cycle after rom_addr

## Operation
- Handshake FSM with two states:
  - EMPTY: pos_ready=1. pos_valid captures xpos/ypos into the pending register → HELD.
  - HELD: pos_ready=0; pos_valid is ignored.
- Frame start is `in.vcount==VER_BLANK_START && in.hcount==0`.
  - In HELD at frame start: pending is copied to active, visible_q←1, → EMPTY.
  - In EMPTY at frame start with pos_valid=1: the value is captured into pending only. It is applied at the next frame start, never in the same cycle.
- Window test uses 12-bit arithmetic, with no wrap past 2047:
  - hit = visible_q && hcount≥ax && hcount<ax+SPRITE_W && vcount≥ay && vcount<ay+SPRITE_H
- Address: rom_addr = (vcount−ay)*SPRITE_W + (hcount−ax). The multiply is a shift because SPRITE_W is a power of two. rom_addr=0 when not hit.
- Output pixel: out.rgb = rom_data when hit_d && !blank_d && rom_data≠TRANSPARENT; otherwise the delayed in.rgb.
- A sprite partially off the right or bottom edge is clipped naturally by the blanking check. No wrap to the opposite edge.
- Reset values:
  - All out fields 0; rom_addr 0; pos_ready 0 during reset, 1 on the first cycle after release.
  - State EMPTY; active/pending 0; visible_q 0. Nothing is drawn until the first position is applied.
- Reset mid-frame: the pipeline clears immediately. Output resumes valid 2 cycles after release.

## Timing
- Latency is 2 cycles for every out field, timing and rgb alike.
  - Stage 1 registers the hit, rom_addr and delayed input.
  - Stage 2 consumes rom_data.
- pos_ready falls the cycle after acceptance. It rises the cycle after the frame-start transfer.
- Throughput is 1 pixel per clock, with no stalls.

## Configuration
- DRAW_SPRITE_MIRROR_EN defined:
  - Adds the input port `mirror` (1 bit), captured with xpos/ypos and applied with them at frame start.
  - When the active mirror=1, the column index becomes SPRITE_W−1−(hcount−ax), a horizontal flip.
- Undefined: the port does not exist and addressing is always unmirrored.

## Structure
- vga_pkg already holds the timing constants (HOR_TOTAL_TIME=1344, VER_TOTAL_TIME=806, VER_BLANK_START=768, etc.).
- Add a `sprite_pos_t` struct {x, y[, mirror]} to vga_pkg.
- Sub-module `delay` (parameter WIDTH, CLK_DEL): a generic register chain used for the timing bundle. It is reusable by later stages.

## Test plan
- No position ever sent, in.rgb=12'hABC for a full frame → out.rgb=12'hABC everywhere; out fields equal in fields delayed exactly 2 cycles.
- Send (100,200) mid-frame → pos_ready=0 next cycle. Sprite absent until vcount 768, then drawn at hcount 100..131, vcount 200..231 on the following frame. Check rom_addr=0 at (100,200) and 1023 at (131,231).
- ROM returns TRANSPARENT at address 5 → background shows at pixel (105,200); ROM colour shows everywhere else in the window.
- Position (1010,760) → drawn columns 1010..1023 and rows 760..767 only; no pixel drawn at hcount<32 or vcount<8.
- pos_valid asserted exactly at frame start in EMPTY → captured, applied at the next frame start. A second pos_valid while HELD is ignored.
- rst asserted at hcount=500, vcount=300 for 3 cycles → out all 0 and pos_ready=0 during reset. Sprite invisible afterwards until a new position is applied.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the sprite position record and the handshake states.
// Defining DRAW_SPRITE_MIRROR_EN adds a horizontal mirror flag to sprite_pos_t.
package vga_pkg;

    localparam int HOR_TOTAL_TIME  = 1344;
    localparam int HOR_BLANK_START = 1024;
    localparam int HOR_SYNC_START  = 1048;
    localparam int HOR_SYNC_TIME   = 136;
    localparam int VER_TOTAL_TIME  = 806;
    localparam int VER_BLANK_START = 768;
    localparam int VER_SYNC_START  = 771;
    localparam int VER_SYNC_TIME   = 6;

    localparam int COORD_W = 11;
    localparam int RGB_W   = 12;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
`ifdef DRAW_SPRITE_MIRROR_EN
        logic               mirror;
`endif
    } sprite_pos_t;

    typedef enum logic {
        EMPTY,
        HELD
    } sprite_state_t;

endpackage

// File: rtl/delay.sv
// Generic register chain: din appears on dout CLK_DEL clock cycles later.
// Cleared asynchronously by rst.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] chain [CLK_DEL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign dout = chain[CLK_DEL-1];

endmodule

// File: rtl/draw_sprite.sv
// Two-stage sprite overlay on the VGA pixel stream; position updates only at frame start.
// Defining DRAW_SPRITE_MIRROR_EN adds the mirror input for horizontally flipped sprites.
module draw_sprite
    import vga_pkg::*;
#(
    parameter int               SPRITE_W    = 32,
    parameter int               SPRITE_H    = 32,
    parameter logic [RGB_W-1:0] TRANSPARENT = 12'h000
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic [COORD_W-1:0]                    in_hcount,
    input  logic [COORD_W-1:0]                    in_vcount,
    input  logic                                  in_hsync,
    input  logic                                  in_vsync,
    input  logic                                  in_hblnk,
    input  logic                                  in_vblnk,
    input  logic [RGB_W-1:0]                      in_rgb,

    output logic [COORD_W-1:0]                    out_hcount,
    output logic [COORD_W-1:0]                    out_vcount,
    output logic                                  out_hsync,
    output logic                                  out_vsync,
    output logic                                  out_hblnk,
    output logic                                  out_vblnk,
    output logic [RGB_W-1:0]                      out_rgb,

    input  logic [COORD_W-1:0]                    xpos,
    input  logic [COORD_W-1:0]                    ypos,
    input  logic                                  pos_valid,
    output logic                                  pos_ready,
`ifdef DRAW_SPRITE_MIRROR_EN
    input  logic                                  mirror,
`endif

    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  rom_addr,
    input  logic [RGB_W-1:0]                      rom_data
);

    localparam int AW     = $clog2(SPRITE_W * SPRITE_H);
    localparam int XW     = $clog2(SPRITE_W);
    localparam int TIME_W = 2 * COORD_W + 4;

    sprite_state_t state;
    sprite_pos_t   req;
    sprite_pos_t   pending;
    sprite_pos_t   active;
    logic          visible_q;
    logic          frame_start;

    always_comb begin
        req   = '0;
        req.x = xpos;
        req.y = ypos;
`ifdef DRAW_SPRITE_MIRROR_EN
        req.mirror = mirror;
`endif
    end

    assign frame_start = (in_vcount == COORD_W'(VER_BLANK_START)) && (in_hcount == '0);

    // Position handshake: one pending slot, promoted to active only at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            pending   <= '0;
            active    <= '0;
            visible_q <= 1'b0;
            pos_ready <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    pos_ready <= 1'b1;
                    if (pos_valid && pos_ready) begin
                        pending   <= req;
                        state     <= HELD;
                        pos_ready <= 1'b0;
                    end
                end
                HELD: begin
                    if (frame_start) begin
                        active    <= pending;
                        visible_q <= 1'b1;
                        state     <= EMPTY;
                        pos_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    logic [11:0]   hc;
    logic [11:0]   vc;
    logic [11:0]   ax;
    logic [11:0]   ay;
    logic [XW-1:0] col;
    logic          hit;
    logic          blank;

    // 12-bit compare so a window starting near 2047 cannot wrap onto low coordinates.
    // rom_addr is driven combinationally so the ROM's one-cycle read lines up with stage 1.
    always_comb begin
        hc    = {1'b0, in_hcount};
        vc    = {1'b0, in_vcount};
        ax    = {1'b0, active.x};
        ay    = {1'b0, active.y};
        col   = XW'(hc - ax);
`ifdef DRAW_SPRITE_MIRROR_EN
        if (active.mirror) begin
            col = ~col;
        end
`endif
        hit   = visible_q
              && (hc >= ax) && (hc < ax + 12'(SPRITE_W))
              && (vc >= ay) && (vc < ay + 12'(SPRITE_H));
        blank = in_hblnk || in_vblnk;
        rom_addr = hit ? AW'({12'(vc - ay), col}) : '0;
    end

    logic             hit_q;
    logic             blank_q;
    logic [RGB_W-1:0] rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            hit_q   <= hit;
            blank_q <= blank;
        end
    end

    delay #(
        .WIDTH   (RGB_W),
        .CLK_DEL (1)
    ) u_rgb_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (in_rgb),
        .dout (rgb_q)
    );

    logic [TIME_W-1:0] timing_in;
    logic [TIME_W-1:0] timing_out;

    assign timing_in = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk};

    delay #(
        .WIDTH   (TIME_W),
        .CLK_DEL (2)
    ) u_timing_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (timing_in),
        .dout (timing_out)
    );

    assign {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk} = timing_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rgb <= '0;
        end else if (hit_q && !blank_q && (rom_data != TRANSPARENT)) begin
            out_rgb <= rom_data;
        end else begin
            out_rgb <= rgb_q;
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// Self-checking bench for draw_sprite: scoreboard of the delayed bundle plus vector tables.
// Drives an arbitrary raster sample rather than whole frames to stay short.
module tb_draw_sprite;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] in_hcount = '0;
    logic [10:0] in_vcount = '0;
    logic        in_hsync  = 1'b0;
    logic        in_vsync  = 1'b0;
    logic        in_hblnk  = 1'b0;
    logic        in_vblnk  = 1'b0;
    logic [11:0] in_rgb    = '0;
    logic [10:0] out_hcount;
    logic [10:0] out_vcount;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_hblnk;
    logic        out_vblnk;
    logic [11:0] out_rgb;
    logic [10:0] xpos      = '0;
    logic [10:0] ypos      = '0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data  = '0;
`ifdef DRAW_SPRITE_MIRROR_EN
    logic        mirror    = 1'b0;
`endif

    always #5 clk = ~clk;

    draw_sprite #(
        .SPRITE_W    (32),
        .SPRITE_H    (32),
        .TRANSPARENT (12'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_hcount  (in_hcount),
        .in_vcount  (in_vcount),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .in_hblnk   (in_hblnk),
        .in_vblnk   (in_vblnk),
        .in_rgb     (in_rgb),
        .out_hcount (out_hcount),
        .out_vcount (out_vcount),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_hblnk  (out_hblnk),
        .out_vblnk  (out_vblnk),
        .out_rgb    (out_rgb),
        .xpos       (xpos),
        .ypos       (ypos),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
`ifdef DRAW_SPRITE_MIRROR_EN
        .mirror     (mirror),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    // Sprite ROM: address 5 is see-through, every other word is distinct and non-zero.
    function automatic logic [11:0] rom_f(input logic [9:0] a);
        return (a == 10'd5) ? 12'h000 : (12'h400 | {2'b00, a});
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    typedef logic [37:0] bundle_t;
    typedef struct {
        int          h;
        int          v;
        logic [11:0] rgb;
        logic [11:0] exp_rgb;
        int          exp_addr;
    } vec_t;

    bundle_t sb_q[$];
    vec_t    tbl[$];
    int      checks   = 0;
    int      failures = 0;
    logic    rst_next = 1'b1;
    logic    m_vis    = 1'b0;
    int      m_x      = 0;
    int      m_y      = 0;

    function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] rgb);
        logic [11:0] d;
        if (m_vis && h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32
            && h < HOR_BLANK_START && v < VER_BLANK_START) begin
            d = rom_f(10'((v - m_y) * 32 + (h - m_x)));
            if (d != 12'h000) return d;
        end
        return rgb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One pixel per call: retire the bundle due now, then drive the next input and queue its result.
    task automatic step(input int h, input int v, input logic [11:0] rgb,
                        input logic [11:0] erg, input logic pv);
        bundle_t e;
        @(negedge clk);
        if (sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            if (rst) e = '0;
            check("out_bundle", {out_hcount, out_vcount, out_hsync, out_vsync,
                                 out_hblnk, out_vblnk, out_rgb}, e);
        end
        rst       = rst_next;
        in_hcount = 11'(h);
        in_vcount = 11'(v);
        in_hsync  = (h >= HOR_SYNC_START) && (h < HOR_SYNC_START + HOR_SYNC_TIME);
        in_vsync  = (v >= VER_SYNC_START) && (v < VER_SYNC_START + VER_SYNC_TIME);
        in_hblnk  = (h >= HOR_BLANK_START);
        in_vblnk  = (v >= VER_BLANK_START);
        in_rgb    = rgb;
        pos_valid = pv;
        if (rst) e = '0;
        else e = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, erg};
        sb_q.push_back(e);
    endtask

    task automatic px(input int h, input int v, input logic [11:0] rgb, input logic pv);
        step(h, v, rgb, model_rgb(h, v, rgb), pv);
    endtask

    task automatic run_tbl(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].h, tbl[i].v, tbl[i].rgb, tbl[i].exp_rgb, 1'b0);
            #1 check(name, 64'(rom_addr), 64'(tbl[i].exp_addr));
        end
    endtask

    int rows[3] = '{10, 767, 770};

    initial begin
        #1 rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            px(1000 + i, 10, 12'hABC, 1'b0);
            #1;
            check("reset_out", {out_hcount, out_vcount, out_hsync, out_vsync,
                                out_hblnk, out_vblnk, out_rgb}, 64'd0);
            check("reset_ready", 64'(pos_ready), 64'd0);
        end
        rst_next = 1'b0;
        px(0, 0, 12'hABC, 1'b0);
        px(1, 0, 12'hABC, 1'b0);
        check("ready_after_reset", 64'(pos_ready), 64'd1);

        // No position ever sent: background passes through, frame start changes nothing.
        foreach (rows[r]) begin
            for (int h = 1000; h < 1060; h++) px(h, rows[r], 12'hABC, 1'b0);
        end
        for (int h = 0; h < 20; h++) px(h, 768, 12'hABC, 1'b0);
        for (int h = 1040; h < 1060; h++) px(h, 772, 12'(h * 7 + 3), 1'b0);
        px(100, 200, 12'hABC, 1'b0);
        #1 check("addr_no_sprite", 64'(rom_addr), 64'd0);

        // Position accepted mid-frame, second request ignored while held.
        xpos = 11'd100;
        ypos = 11'd200;
        px(500, 300, 12'hABC, 1'b1);
        px(501, 300, 12'hABC, 1'b0);
        check("ready_fall", 64'(pos_ready), 64'd0);
        px(100, 200, 12'hABC, 1'b0);
        #1 check("addr_before_apply", 64'(rom_addr), 64'd0);
        xpos = 11'd300;
        ypos = 11'd300;
        px(502, 300, 12'hABC, 1'b1);
        px(503, 300, 12'hABC, 1'b0);
        check("ready_held", 64'(pos_ready), 64'd0);
        px(0, 768, 12'hABC, 1'b0);
        m_vis = 1'b1;
        m_x   = 100;
        m_y   = 200;
        px(1, 768, 12'hABC, 1'b0);
        check("ready_rise", 64'(pos_ready), 64'd1);

        tbl.delete();
        tbl.push_back('{100, 200, 12'hABC, 12'h400, 0});
        tbl.push_back('{131, 231, 12'hABC, 12'h7FF, 1023});
        tbl.push_back('{105, 200, 12'hABC, 12'hABC, 5});
        tbl.push_back('{106, 200, 12'hABC, 12'h406, 6});
        tbl.push_back('{99,  200, 12'hABC, 12'hABC, 0});
        tbl.push_back('{132, 231, 12'hABC, 12'hABC, 0});
        tbl.push_back('{100, 199, 12'hABC, 12'hABC, 0});
        tbl.push_back('{131, 232, 12'hABC, 12'hABC, 0});
        tbl.push_back('{110, 210, 12'h123, 12'h54A, 330});
        tbl.push_back('{115, 225, 12'hABC, 12'h72F, 815});
        tbl.push_back('{300, 300, 12'hABC, 12'hABC, 0});
        run_tbl("addr_sprite");
        for (int h = 95; h < 140; h++) px(h, 200, 12'(h), 1'b0);
        for (int h = 95; h < 140; h++) px(h, 231, 12'hABC, 1'b0);

        // Request exactly at frame start while empty: captured now, applied next frame start.
        xpos = 11'd1010;
        ypos = 11'd760;
        px(0, 768, 12'hABC, 1'b1);
        px(1, 768, 12'hABC, 1'b0);
        check("ready_fs_capture", 64'(pos_ready), 64'd0);
        px(110, 210, 12'hABC, 1'b0);
        px(1012, 762, 12'hABC, 1'b0);
        px(0, 768, 12'hABC, 1'b0);
        m_x = 1010;
        m_y = 760;
        px(1, 768, 12'hABC, 1'b0);
        check("ready_fs_apply", 64'(pos_ready), 64'd1);

        tbl.delete();
        tbl.push_back('{1010, 760, 12'hABC, 12'h400, 0});
        tbl.push_back('{1023, 767, 12'hABC, 12'h4ED, 237});
        tbl.push_back('{1024, 760, 12'hABC, 12'hABC, 14});
        tbl.push_back('{1041, 770, 12'hABC, 12'hABC, 351});
        tbl.push_back('{1042, 760, 12'hABC, 12'hABC, 0});
        tbl.push_back('{5,    761, 12'hABC, 12'hABC, 0});
        tbl.push_back('{1015, 3,   12'hABC, 12'hABC, 0});
        tbl.push_back('{31,   7,   12'hABC, 12'hABC, 0});
        tbl.push_back('{1012, 762, 12'h055, 12'h442, 66});
        tbl.push_back('{110,  210, 12'hABC, 12'hABC, 0});
        run_tbl("addr_clip");
        for (int h = 0; h < 40; h++) px(h, 761, 12'hABC, 1'b0);
        for (int h = 1000; h < 1050; h++) px(h, 763, 12'(h + 1), 1'b0);

        // Reset mid-frame: everything clears and the sprite stays hidden afterwards.
        px(500, 300, 12'hABC, 1'b0);
        rst_next = 1'b1;
        m_vis    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            px(501 + i, 300, 12'hABC, 1'b0);
            #1;
            check("midreset_out", {out_hcount, out_vcount, out_hsync, out_vsync,
                                   out_hblnk, out_vblnk, out_rgb}, 64'd0);
            check("midreset_ready", 64'(pos_ready), 64'd0);
        end
        rst_next = 1'b0;
        px(504, 300, 12'hABC, 1'b0);
        px(505, 300, 12'hABC, 1'b0);
        check("ready_after_midreset", 64'(pos_ready), 64'd1);
        px(1012, 762, 12'hABC, 1'b0);
        #1 check("addr_after_midreset", 64'(rom_addr), 64'd0);
        px(0, 768, 12'hABC, 1'b0);
        for (int h = 1005; h < 1030; h++) px(h, 762, 12'hABC, 1'b0);
        px(0, 0, 12'h000, 1'b0);
        px(1, 0, 12'h000, 1'b0);
        px(2, 0, 12'h000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
